// File: rtl/mem_arbiter.sv
// -----------------------------------------------------------------------------
// mem_arbiter
//
// Two-master arbiter in front of a single-ported shared memory. Master 0 is
// the instruction fetch unit (read only); master 1 is the load/store unit
// (read or byte-strobed write). Only one transaction is outstanding at a time:
// a request is granted in S_IDLE, presented to memory from registered fields
// in S_REQ, and completed by the memory response or write ack in S_RESP.
//
// Ports
//   clk, rst                 clock and asynchronous active-low reset
//   m0_req_valid/_ready      IFU request handshake, m0_addr fetch address
//   m0_resp_valid, m0_rdata  IFU read data, one-cycle pulse
//   m1_req_valid/_ready      LSU request handshake
//   m1_addr, m1_wen,
//   m1_wdata, m1_wstrb       LSU request fields
//   m1_resp_valid, m1_rdata  LSU read data or write ack, one-cycle pulse
//   s_req_valid/_ready       request handshake to the shared memory
//   s_addr, s_wen,
//   s_wdata, s_wstrb         registered request fields to memory
//   s_resp_valid, s_rdata    memory response; always accepted
//
// Parameters
//   ADDR_W  address width
//   RR_EN   1: round-robin on a tie, 0: LSU always wins a tie
// -----------------------------------------------------------------------------
module mem_arbiter #(
  parameter int unsigned ADDR_W = 32,
  parameter bit          RR_EN  = 1'b1
) (
  input  logic              clk,
  input  logic              rst,

  input  logic              m0_req_valid,
  output logic              m0_req_ready,
  input  logic [ADDR_W-1:0] m0_addr,
  output logic              m0_resp_valid,
  output logic [31:0]       m0_rdata,

  input  logic              m1_req_valid,
  output logic              m1_req_ready,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic              m1_wen,
  input  logic [31:0]       m1_wdata,
  input  logic [3:0]        m1_wstrb,
  output logic              m1_resp_valid,
  output logic [31:0]       m1_rdata,

  output logic              s_req_valid,
  input  logic              s_req_ready,
  output logic [ADDR_W-1:0] s_addr,
  output logic              s_wen,
  output logic [31:0]       s_wdata,
  output logic [3:0]        s_wstrb,
  input  logic              s_resp_valid,
  input  logic [31:0]       s_rdata
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_RESP = 2'd2
  } state_e;

  localparam logic ID_IFU = 1'b0;
  localparam logic ID_LSU = 1'b1;

  state_e            state_q, state_d;
  logic              gnt_q,   gnt_d;    // master owning the current transaction
  logic              last_q,  last_d;   // master served by the last completed transaction
  logic [ADDR_W-1:0] addr_q,  addr_d;
  logic              wen_q,   wen_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [3:0]        wstrb_q, wstrb_d;

  logic              win_id;
  logic              rdy0, rdy1;
  logic              resp_fire;

  // Arbitration winner, meaningful only when at least one master requests.
  // A lone LSU request selects ID_LSU; otherwise IFU unless a tie resolves
  // to the LSU.
  always_comb begin
    if (m0_req_valid && m1_req_valid) begin
      win_id = RR_EN ? ~last_q : ID_LSU;
    end else begin
      win_id = m1_req_valid ? ID_LSU : ID_IFU;
    end
  end

  // NOTE: every signal assigned in this block gets a default before the case,
  // so no path leaves a value unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    last_d  = last_q;
    addr_d  = addr_q;
    wen_d   = wen_q;
    wdata_d = wdata_q;
    wstrb_d = wstrb_q;
    rdy0    = 1'b0;
    rdy1    = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (m0_req_valid || m1_req_valid) begin
          rdy0    = (win_id == ID_IFU);
          rdy1    = (win_id == ID_LSU);
          gnt_d   = win_id;
          state_d = S_REQ;
          if (win_id == ID_LSU) begin
            addr_d  = m1_addr;
            wen_d   = m1_wen;
            wdata_d = m1_wdata;
            wstrb_d = m1_wstrb;
          end else begin
            // Fetches are always reads with no write payload on the bus.
            addr_d  = m0_addr;
            wen_d   = 1'b0;
            wdata_d = '0;
            wstrb_d = '0;
          end
        end
      end

      S_REQ: begin
        if (s_req_ready) begin
          state_d = S_RESP;
        end
      end

      S_RESP: begin
        if (s_resp_valid) begin
          last_d  = gnt_q;
          state_d = S_IDLE;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values of the others.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      gnt_q   <= ID_IFU;
      last_q  <= ID_LSU;   // IFU wins the first tie after reset
      addr_q  <= '0;
      wen_q   <= 1'b0;
      wdata_q <= '0;
      wstrb_q <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      last_q  <= last_d;
      addr_q  <= addr_d;
      wen_q   <= wen_d;
      wdata_q <= wdata_d;
      wstrb_q <= wstrb_d;
    end
  end

  // The ready outputs come straight from the inputs in S_IDLE, so they are
  // qualified with reset to keep every output low while reset is asserted.
  assign m0_req_ready = rdy0 & rst;
  assign m1_req_ready = rdy1 & rst;

  assign s_req_valid = (state_q == S_REQ);
  assign s_addr      = addr_q;
  assign s_wen       = wen_q;
  assign s_wdata     = wdata_q;
  assign s_wstrb     = wstrb_q;

  // Responses arriving outside S_RESP are dropped here.
  assign resp_fire     = (state_q == S_RESP) && s_resp_valid;
  assign m0_resp_valid = resp_fire && (gnt_q == ID_IFU);
  assign m1_resp_valid = resp_fire && (gnt_q == ID_LSU);
  assign m0_rdata      = m0_resp_valid ? s_rdata : '0;
  // A write ack carries no data back to the LSU.
  assign m1_rdata      = (m1_resp_valid && !wen_q) ? s_rdata : '0;

endmodule

// File: tb/tb_mem_arbiter.sv
`timescale 1ns/1ps
module tb_mem_arbiter;

  localparam int AW = 32;

  logic          clk = 1'b0;
  logic          rst;

  logic          m0_req_valid, m0_req_ready, m0_resp_valid;
  logic [AW-1:0] m0_addr;
  logic [31:0]   m0_rdata;
  logic          m1_req_valid, m1_req_ready, m1_resp_valid, m1_wen;
  logic [AW-1:0] m1_addr;
  logic [31:0]   m1_wdata, m1_rdata;
  logic [3:0]    m1_wstrb;
  logic          s_req_valid, s_req_ready, s_wen, s_resp_valid;
  logic [AW-1:0] s_addr;
  logic [31:0]   s_wdata, s_rdata;
  logic [3:0]    s_wstrb;

  // Fixed-priority instance: shares the master inputs, talks to an always
  // ready, always responding memory.
  logic          fp_m0_req_ready, fp_m0_resp_valid, fp_m1_req_ready, fp_m1_resp_valid;
  logic [31:0]   fp_m0_rdata, fp_m1_rdata, fp_s_wdata;
  logic          fp_s_req_valid, fp_s_wen;
  logic [AW-1:0] fp_s_addr;
  logic [3:0]    fp_s_wstrb;

  typedef struct packed {
    logic        id;
    logic [31:0] data;
  } exp_t;

  exp_t exp_q[$];
  logic gnt_log[$];
  exp_t mon_e;
  logic mon_id;
  logic [31:0] mon_data;

  int vectors     = 0;
  int miscompares = 0;
  bit mem_auto    = 1'b1;
  int stall_cnt   = 0;

  always #5 clk = ~clk;

  mem_arbiter #(.ADDR_W(AW), .RR_EN(1'b1)) dut (
    .clk(clk), .rst(rst),
    .m0_req_valid(m0_req_valid), .m0_req_ready(m0_req_ready), .m0_addr(m0_addr),
    .m0_resp_valid(m0_resp_valid), .m0_rdata(m0_rdata),
    .m1_req_valid(m1_req_valid), .m1_req_ready(m1_req_ready), .m1_addr(m1_addr),
    .m1_wen(m1_wen), .m1_wdata(m1_wdata), .m1_wstrb(m1_wstrb),
    .m1_resp_valid(m1_resp_valid), .m1_rdata(m1_rdata),
    .s_req_valid(s_req_valid), .s_req_ready(s_req_ready), .s_addr(s_addr),
    .s_wen(s_wen), .s_wdata(s_wdata), .s_wstrb(s_wstrb),
    .s_resp_valid(s_resp_valid), .s_rdata(s_rdata)
  );

  mem_arbiter #(.ADDR_W(AW), .RR_EN(1'b0)) dut_fp (
    .clk(clk), .rst(rst),
    .m0_req_valid(m0_req_valid), .m0_req_ready(fp_m0_req_ready), .m0_addr(m0_addr),
    .m0_resp_valid(fp_m0_resp_valid), .m0_rdata(fp_m0_rdata),
    .m1_req_valid(m1_req_valid), .m1_req_ready(fp_m1_req_ready), .m1_addr(m1_addr),
    .m1_wen(m1_wen), .m1_wdata(m1_wdata), .m1_wstrb(m1_wstrb),
    .m1_resp_valid(fp_m1_resp_valid), .m1_rdata(fp_m1_rdata),
    .s_req_valid(fp_s_req_valid), .s_req_ready(1'b1), .s_addr(fp_s_addr),
    .s_wen(fp_s_wen), .s_wdata(fp_s_wdata), .s_wstrb(fp_s_wstrb),
    .s_resp_valid(1'b1), .s_rdata(32'h0)
  );

  // Memory contents model.
  function automatic logic [31:0] mem_f(input logic [AW-1:0] a);
    if (a == 32'h8000_0000) return 32'h0000_0413;
    return {a[15:0], ~a[15:0]};
  endfunction

  function automatic logic [137:0] outs_vec();
    return {m0_req_ready, m1_req_ready, m0_resp_valid, m1_resp_valid, s_req_valid, s_wen,
            m0_rdata, m1_rdata, s_addr, s_wdata, s_wstrb};
  endfunction

  // Per-cycle invariants and scoreboard: expectations are pushed when a
  // request is accepted and popped when a response appears.
  always @(negedge clk) begin
    vectors++;
    if ((m0_req_ready && m1_req_ready) !== 1'b0) begin
      miscompares++;
      $display("FAIL both_ready: m0_req_ready=%b m1_req_ready=%b, want not both", m0_req_ready, m1_req_ready);
    end
    vectors++;
    if ((!m0_resp_valid && m0_rdata !== 32'h0) || (!m1_resp_valid && m1_rdata !== 32'h0)) begin
      miscompares++;
      $display("FAIL rdata_idle: m0_rdata=%h m1_rdata=%h with resp_valid=%b%b, want 0", m0_rdata, m1_rdata, m0_resp_valid, m1_resp_valid);
    end
    if (m0_resp_valid === 1'b1 || m1_resp_valid === 1'b1) begin
      vectors++;
      mon_id   = m1_resp_valid;
      mon_data = m1_resp_valid ? m1_rdata : m0_rdata;
      if (m0_resp_valid && m1_resp_valid) begin
        miscompares++;
        $display("FAIL resp_both: both resp_valid high, want one");
      end else if (exp_q.size() == 0) begin
        miscompares++;
        $display("FAIL resp_unexpected: master %0d rdata %h, want no response", mon_id, mon_data);
      end else begin
        mon_e = exp_q.pop_front();
        if (mon_id !== mon_e.id || mon_data !== mon_e.data) begin
          miscompares++;
          $display("FAIL resp: got master %0d rdata %h, want master %0d rdata %h", mon_id, mon_data, mon_e.id, mon_e.data);
        end
      end
    end
    if (m0_req_valid && m0_req_ready) begin
      exp_q.push_back('{id: 1'b0, data: mem_f(m0_addr)});
      gnt_log.push_back(1'b0);
    end
    if (m1_req_valid && m1_req_ready) begin
      exp_q.push_back('{id: 1'b1, data: (m1_wen ? 32'h0 : mem_f(m1_addr))});
      gnt_log.push_back(1'b1);
    end
  end

  // One clock; returns 1ns after the rising edge with the memory model updated.
  task automatic step();
    bit fire;
    fire = s_req_valid && s_req_ready;
    @(posedge clk);
    #1;
    if (mem_auto) begin
      s_resp_valid = fire;
      if (s_req_valid && stall_cnt > 0) begin
        s_req_ready = 1'b0;
        stall_cnt--;
      end else begin
        s_req_ready = 1'b1;
      end
    end
    s_rdata = s_wen ? 32'hFFFF_FFFF : mem_f(s_addr);
  endtask

  task automatic reset_pulse();
    rst = 1'b0;
    exp_q.delete();
    step();
    rst = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    m0_req_valid = 1'b1; m0_addr = 32'h8000_0000;
    m1_req_valid = 1'b1; m1_addr = 32'h8000_0004; m1_wen = 1'b1;
    m1_wdata = 32'h1111_2222; m1_wstrb = 4'hF;
    s_req_ready = 1'b1; s_resp_valid = 1'b1; s_rdata = 32'h5555_AAAA;
    @(negedge clk);
    vectors++;
    if (outs_vec() !== '0) begin
      miscompares++;
      $display("FAIL reset_outputs: outputs %h, want all 0", outs_vec());
    end
    m0_req_valid = 1'b0; m1_req_valid = 1'b0; m1_wen = 1'b0; s_resp_valid = 1'b0;
    @(posedge clk);
    #1 rst = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      @(negedge clk);
      vectors++;
      if (outs_vec() !== '0) begin
        miscompares++;
        $display("FAIL idle_outputs cycle %0d: outputs %h, want all 0", i, outs_vec());
      end
    end
  endtask

  task automatic test_ifu_read();
    step();
    m0_req_valid = 1'b1; m0_addr = 32'h8000_0000;
    @(negedge clk);
    vectors++;
    if (m0_req_ready !== 1'b1 || m1_req_ready !== 1'b0 || s_req_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL ifu_grant: ready=%b%b s_req_valid=%b, want ready=10 s_req_valid=0", m0_req_ready, m1_req_ready, s_req_valid);
    end
    step();
    m0_req_valid = 1'b0; m0_addr = 32'h1234_5678;
    @(negedge clk);
    vectors++;
    if (s_req_valid !== 1'b1 || s_addr !== 32'h8000_0000 || s_wen !== 1'b0 || s_wdata !== 32'h0 || s_wstrb !== 4'h0) begin
      miscompares++;
      $display("FAIL ifu_req: valid=%b addr=%h wen=%b wdata=%h wstrb=%h, want 1 80000000 0 0 0", s_req_valid, s_addr, s_wen, s_wdata, s_wstrb);
    end
    step();
    @(negedge clk);
    vectors++;
    if (s_req_valid !== 1'b0 || m0_resp_valid !== 1'b1 || m0_rdata !== 32'h0000_0413 || m1_resp_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL ifu_resp: s_req_valid=%b m0_resp=%b rdata=%h m1_resp=%b, want 0 1 00000413 0", s_req_valid, m0_resp_valid, m0_rdata, m1_resp_valid);
    end
    step();
    @(negedge clk);
    vectors++;
    if (s_req_valid !== 1'b0 || m0_resp_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL ifu_after: s_req_valid=%b m0_resp=%b, want 0 0", s_req_valid, m0_resp_valid);
    end
  endtask

  task automatic test_lsu_write();
    step();
    stall_cnt = 3;
    m1_req_valid = 1'b1; m1_addr = 32'h8000_1000; m1_wen = 1'b1;
    m1_wdata = 32'hDEAD_BEEF; m1_wstrb = 4'h3;
    @(negedge clk);
    vectors++;
    if (m1_req_ready !== 1'b1 || m0_req_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL lsu_grant: ready=%b%b, want 01", m0_req_ready, m1_req_ready);
    end
    step();
    m1_req_valid = 1'b0; m1_addr = 32'hFFFF_0000;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      vectors++;
      if (s_req_valid !== 1'b1 || s_addr !== 32'h8000_1000 || s_wen !== 1'b1 ||
          s_wdata !== 32'hDEAD_BEEF || s_wstrb !== 4'h3 || m1_resp_valid !== 1'b0) begin
        miscompares++;
        $display("FAIL lsu_hold cycle %0d: valid=%b addr=%h wen=%b wdata=%h wstrb=%h resp=%b, want 1 80001000 1 deadbeef 3 0",
                 i, s_req_valid, s_addr, s_wen, s_wdata, s_wstrb, m1_resp_valid);
      end
      step();
    end
    @(negedge clk);
    vectors++;
    if (s_req_valid !== 1'b0 || m1_resp_valid !== 1'b1 || m1_rdata !== 32'h0 || m0_resp_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL lsu_ack: s_req_valid=%b m1_resp=%b m1_rdata=%h m0_resp=%b, want 0 1 0 0", s_req_valid, m1_resp_valid, m1_rdata, m0_resp_valid);
    end
    step();
    @(negedge clk);
    vectors++;
    if (m1_resp_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL lsu_pulse: m1_resp_valid=%b one cycle after ack, want 0", m1_resp_valid);
    end
  endtask

  task automatic test_round_robin();
    logic want;
    reset_pulse();
    gnt_log.delete();
    m1_wen = 1'b0;
    m0_req_valid = 1'b1; m0_addr = 32'h8000_0100;
    m1_req_valid = 1'b1; m1_addr = 32'h8000_2000;
    for (int i = 0; i < 15; i++) step();
    m0_req_valid = 1'b0; m1_req_valid = 1'b0;
    for (int i = 0; i < 4; i++) step();
    vectors++;
    if (gnt_log.size() != 5) begin
      miscompares++;
      $display("FAIL rr_count: %0d grants in 15 cycles, want 5", gnt_log.size());
    end
    want = 1'b0;
    foreach (gnt_log[i]) begin
      vectors++;
      if (gnt_log[i] !== want) begin
        miscompares++;
        $display("FAIL rr_order grant %0d: master %0d, want %0d", i, gnt_log[i], want);
      end
      want = ~want;
    end
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL rr_drain: %0d responses outstanding, want 0", exp_q.size());
    end
  endtask

  task automatic test_fixed_priority();
    int  n_lsu;
    bit  seen;
    reset_pulse();
    n_lsu = 0;
    m1_wen = 1'b0;
    m0_req_valid = 1'b1; m0_addr = 32'h8000_0200;
    m1_req_valid = 1'b1; m1_addr = 32'h8000_3000;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      vectors++;
      if (fp_m0_req_ready !== 1'b0) begin
        miscompares++;
        $display("FAIL fp_ifu_blocked cycle %0d: fp m0_req_ready=%b, want 0", i, fp_m0_req_ready);
      end
      if (fp_m1_req_ready === 1'b1) n_lsu++;
      step();
    end
    vectors++;
    if (n_lsu != 5) begin
      miscompares++;
      $display("FAIL fp_lsu_count: %0d LSU grants in 15 cycles, want 5", n_lsu);
    end
    m1_req_valid = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 6 && !seen; i++) begin
      @(negedge clk);
      if (fp_m0_req_ready === 1'b1) seen = 1'b1;
      step();
    end
    vectors++;
    if (!seen) begin
      miscompares++;
      $display("FAIL fp_ifu_alone: fp m0_req_ready never 1 within 6 cycles, want a grant");
    end
    m0_req_valid = 1'b0;
    for (int i = 0; i < 4; i++) step();
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL fp_drain: %0d responses outstanding, want 0", exp_q.size());
    end
  endtask

  task automatic test_reset_abort();
    step();
    mem_auto = 1'b0;
    s_req_ready = 1'b1; s_resp_valid = 1'b0;
    m0_req_valid = 1'b1; m0_addr = 32'h8000_0040;
    @(negedge clk);
    vectors++;
    if (m0_req_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL abort_grant: m0_req_ready=%b, want 1", m0_req_ready);
    end
    step();
    m0_req_valid = 1'b0;
    step();
    @(negedge clk);
    vectors++;
    if (s_req_valid !== 1'b0 || m0_resp_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL abort_wait: s_req_valid=%b m0_resp=%b, want 0 0", s_req_valid, m0_resp_valid);
    end
    #1 rst = 1'b0;
    exp_q.delete();
    #1;
    vectors++;
    if (outs_vec() !== '0) begin
      miscompares++;
      $display("FAIL abort_reset: outputs %h, want all 0", outs_vec());
    end
    @(posedge clk);
    #1 rst = 1'b1;
    step();
    s_resp_valid = 1'b1; s_rdata = 32'hCAFE_F00D;
    @(negedge clk);
    vectors++;
    if (m0_resp_valid !== 1'b0 || m1_resp_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL late_resp: resp_valid=%b%b, want 00", m0_resp_valid, m1_resp_valid);
    end
    step();
    s_resp_valid = 1'b0;
    mem_auto = 1'b1;
    m0_req_valid = 1'b1; m0_addr = 32'h8000_0000;
    @(negedge clk);
    vectors++;
    if (m0_req_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL abort_regrant: m0_req_ready=%b, want 1", m0_req_ready);
    end
    step();
    m0_req_valid = 1'b0;
    for (int i = 0; i < 3; i++) step();
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL abort_complete: %0d responses outstanding, want 0", exp_q.size());
    end
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_ifu_read();
    test_lsu_write();
    test_ifu_read();          // m1 write fields still driven: IFU grant must not carry them
    test_round_robin();
    test_fixed_priority();
    test_reset_abort();
    step();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
